// File: rtl/stream_demux_pkg.sv
// Shared definitions for the stream_demux_n slice.
// Holds the two-state FSM encoding and the default widths used by
// stream_demux_n and demux_sat_cnt.
package stream_demux_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } demux_state_e;

  localparam int unsigned DEMUX_W_DEF     = 8;
  localparam int unsigned DEMUX_N_DEF     = 4;
  localparam int unsigned DEMUX_CNT_W_DEF = 16;

endpackage

// File: rtl/demux_sat_cnt.sv
// Saturating up-counter used for per-channel transfer statistics.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset, clears the count
//   inc - count one event this cycle
//   q   - current count; sticks at all-ones
module demux_sat_cnt
  import stream_demux_pkg::*;
#(
  parameter int unsigned CNT_W = DEMUX_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (inc && (q_q != {CNT_W{1'b1}})) begin
      q_d = q_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/stream_demux_n.sv
// Registered 1-to-N stream demultiplexer with valid/ready handshake.
// Each accepted beat is stored in a single-entry output register and
// presented one cycle later on the channel picked by in_sel. A drain and a
// new accept can happen in the same cycle, so a ready target sees one beat
// per cycle. Beats addressed to a channel >= N are accepted, dropped, and
// flagged with a one-cycle err_sel pulse.
// Build option: define DEMUX_XFER_CNT_EN to add one saturating transfer
// counter per channel on cnt_bus; otherwise cnt_bus is tied to zero.
// Ports:
//   clk, rst            - clock and synchronous active-high reset
//   in_data/in_sel      - input payload and destination channel
//   in_valid/in_ready   - input handshake
//   out_data            - payload shared by all channels
//   out_valid/out_ready - per-channel one-hot valid and ready
//   err_sel             - illegal-select pulse
//   cnt_bus             - packed per-channel transfer counters
module stream_demux_n
  import stream_demux_pkg::*;
#(
  parameter int unsigned W     = DEMUX_W_DEF,
  parameter int unsigned N     = DEMUX_N_DEF,
  parameter int unsigned SW    = 2,
  parameter int unsigned CNT_W = DEMUX_CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [W-1:0]       in_data,
  input  logic [SW-1:0]      in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [W-1:0]       out_data,
  output logic [N-1:0]       out_valid,
  input  logic [N-1:0]       out_ready,
  output logic               err_sel,
  output logic [N*CNT_W-1:0] cnt_bus
);

  demux_state_e  state_q, state_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [W-1:0]  data_q, data_d;
  logic          err_q, err_d;

  logic sel_ready;
  logic sel_legal;
  logic accept;
  logic drain;

  // Decode the held select once: only the addressed channel's ready counts.
  always_comb begin
    sel_ready = 1'b0;
    out_valid = '0;
    for (int k = 0; k < N; k++) begin
      if (sel_q == SW'(k)) begin
        sel_ready    = out_ready[k];
        out_valid[k] = (state_q == ST_FULL);
      end
    end
  end

  assign sel_legal = (32'(in_sel) < N);
  assign in_ready  = (state_q == ST_EMPTY) ? 1'b1 : sel_ready;
  assign accept    = in_valid && in_ready;
  assign drain     = (state_q == ST_FULL) && sel_ready;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    data_d  = data_q;
    err_d   = accept && !sel_legal;
    if (accept && sel_legal) begin
      state_d = ST_FULL;
      sel_d   = in_sel;
      data_d  = in_data;
    end else if (drain) begin
      // out_data deliberately keeps the drained value.
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      sel_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign out_data = data_q;
  assign err_sel  = err_q;

`ifdef DEMUX_XFER_CNT_EN
  for (genvar k = 0; k < N; k++) begin : g_cnt
    demux_sat_cnt #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk(clk),
      .rst(rst),
      .inc(out_valid[k] & out_ready[k]),
      .q  (cnt_bus[k*CNT_W +: CNT_W])
    );
  end
`else
  assign cnt_bus = '0;
`endif

endmodule
